// File: rtl/operand_loader.sv
// Serial-to-parallel operand feeder for the three-operand comparator.
// Ports: clk, rst_n, in_data/in_valid/in_ready (beat stream), flush,
//   A/B/C + ops_valid/ops_ready (triple out), load_count, busy,
//   timeout_err. Optional mid-triple abort: define LOADER_TIMEOUT_EN.
module operand_loader #(
  parameter int N     = 5,
  parameter int CNT_W = 8
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B,
  output logic [N-1:0]     C,
  output logic             ops_valid,
  input  logic             ops_ready,
  output logic [CNT_W-1:0] load_count,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LA   = 3'd1;
  localparam logic [2:0] S_LB   = 3'd2;
  localparam logic [2:0] S_LC   = 3'd3;
  localparam logic [2:0] S_PR   = 3'd4;

  logic [2:0] state;
  logic       armed;
  logic       accept;
  logic       abort;

  assign in_ready  = (state == S_LA) | (state == S_LB)
                   | (state == S_LC);
  assign busy      = (state == S_LB) | (state == S_LC);
  assign ops_valid = (state == S_PR);
  assign accept    = in_valid & in_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;

  // Abort fires on the idle cycle that would bring the count to TIMEOUT.
  assign abort = busy & ~accept
               & (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort & ~flush;
      if (flush | abort | accept | ~busy)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      A          <= '0;
      B          <= '0;
      C          <= '0;
      load_count <= '0;
    end else if (state == S_IDLE) begin
      // Spend one full cycle in IDLE after release.
      armed <= 1'b1;
      if (armed)
        state <= S_LA;
    end else if (flush | abort) begin
      state <= S_LA;
      A     <= '0;
      B     <= '0;
      C     <= '0;
    end else begin
      case (state)
        S_LA: if (accept) begin
          A     <= in_data;
          state <= S_LB;
        end
        S_LB: if (accept) begin
          B     <= in_data;
          state <= S_LC;
        end
        S_LC: if (accept) begin
          C     <= in_data;
          state <= S_PR;
        end
        S_PR: if (ops_ready) begin
          load_count <= load_count + 1'b1;
          state      <= S_LA;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader.
// Table-driven triples plus hand-written corner sequences.
module tb_operand_loader;

  localparam int N     = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [N-1:0]     A, B, C;
  logic             ops_valid;
  logic             ops_ready;
  logic [CNT_W-1:0] load_count;
  logic             busy;
  logic             timeout_err;

  operand_loader #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .A(A), .B(B), .C(C),
    .ops_valid(ops_valid), .ops_ready(ops_ready),
    .load_count(load_count), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    int           stall;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [3*N-1:0]   sb[$];
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Handshake happens at the next rising edge; check the presented triple.
  always @(negedge clk) begin
    if (rst_n && ops_valid && ops_ready) begin
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        logic [3*N-1:0] e;
        e = sb.pop_front();
        chk("sb_A", int'(A), int'(e[3*N-1:2*N]));
        chk("sb_B", int'(B), int'(e[2*N-1:N]));
        chk("sb_C", int'(C), int'(e[N-1:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [N-1:0] d);
    int ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        step();
        ok = 1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    chk("beat_accepted", ok, 1);
  endtask

  task automatic send_triple(input logic [N-1:0] a,
                             input logic [N-1:0] b,
                             input logic [N-1:0] c);
    sb.push_back({a, b, c});
    send_beat(a);
    send_beat(b);
    send_beat(c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_A", int'(A), 0);
    chk("rst_B", int'(B), 0);
    chk("rst_C", int'(C), 0);
    chk("rst_valid", int'(ops_valid), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(load_count), 0);
    chk("rst_terr", int'(timeout_err), 0);
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = '0;
    step();
    chk("idle_ready", int'(in_ready), 0);
    step();
    chk("first_ready", int'(in_ready), 1);
  endtask

  vec_t tbl[6];

  initial begin
    int pulses;
    int pulse_at;

    tbl[0] = '{a: 5'd0,  b: 5'd0,  c: 5'd0,  stall: 0};
    tbl[1] = '{a: 5'd31, b: 5'd31, c: 5'd31, stall: 2};
    tbl[2] = '{a: 5'd1,  b: 5'd16, c: 5'd30, stall: 0};
    tbl[3] = '{a: 5'd31, b: 5'd0,  c: 5'd15, stall: 1};
    tbl[4] = '{a: 5'd10, b: 5'd21, c: 5'd5,  stall: 3};
    tbl[5] = '{a: 5'd17, b: 5'd8,  c: 5'd24, stall: 0};

    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    ops_ready = 1'b0;
    #3;
    do_reset();

    // Back-to-back triple with ops_ready already high.
    ops_ready = 1'b1;
    send_triple(5'd20, 5'd7, 5'd3);
    chk("t1_valid", int'(ops_valid), 1);
    chk("t1_A", int'(A), 20);
    chk("t1_B", int'(B), 7);
    chk("t1_C", int'(C), 3);
    chk("t1_busy", int'(busy), 0);
    chk("t1_inrdy_pr", int'(in_ready), 0);
    step();
    exp_cnt++;
    chk("t1_valid_drop", int'(ops_valid), 0);
    chk("t1_inrdy", int'(in_ready), 1);
    chk("t1_cnt", int'(load_count), int'(exp_cnt));

    // Stalled consumer.
    ops_ready = 1'b0;
    send_triple(5'd9, 5'd9, 5'd9);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", int'(ops_valid), 1);
      chk("t2_A", int'(A), 9);
      chk("t2_B", int'(B), 9);
      chk("t2_C", int'(C), 9);
      chk("t2_inrdy", int'(in_ready), 0);
      step();
    end
    chk("t2_cnt_hold", int'(load_count), int'(exp_cnt));
    ops_ready = 1'b1;
    step();
    exp_cnt++;
    chk("t2_valid_drop", int'(ops_valid), 0);
    chk("t2_cnt", int'(load_count), int'(exp_cnt));

    // Flush with a beat offered in the same cycle.
    send_beat(5'd4);
    send_beat(5'd12);
    chk("t3_busy_pre", int'(busy), 1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd30;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t3_A", int'(A), 0);
    chk("t3_B", int'(B), 0);
    chk("t3_C", int'(C), 0);
    chk("t3_busy", int'(busy), 0);
    chk("t3_inrdy", int'(in_ready), 1);
    chk("t3_valid", int'(ops_valid), 0);
    chk("t3_cnt", int'(load_count), int'(exp_cnt));

    // Table of triples with varying consumer stall.
    foreach (tbl[k]) begin
      ops_ready = (tbl[k].stall == 0);
      send_triple(tbl[k].a, tbl[k].b, tbl[k].c);
      chk("tbl_valid", int'(ops_valid), 1);
      chk("tbl_A", int'(A), int'(tbl[k].a));
      chk("tbl_B", int'(B), int'(tbl[k].b));
      chk("tbl_C", int'(C), int'(tbl[k].c));
      repeat (tbl[k].stall) step();
      chk("tbl_hold", int'(ops_valid), 1);
      ops_ready = 1'b1;
      step();
      exp_cnt++;
      chk("tbl_drop", int'(ops_valid), 0);
      chk("tbl_cnt", int'(load_count), int'(exp_cnt));
    end

    // Gapped stream: valid 1,0,0,1,0,1.
    begin
      logic [5:0] vpat;
      logic [N-1:0] dpat[6];
      vpat = 6'b101001;
      dpat = '{5'd1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd3};
      sb.push_back({5'd1, 5'd2, 5'd3});
      ops_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        in_valid = vpat[i];
        in_data  = vpat[i] ? dpat[i] : N'($urandom);
        step();
        if (i < 5) chk("gap_busy", int'(busy), 1);
      end
      in_valid = 1'b0;
      chk("gap_busy_end", int'(busy), 0);
      chk("gap_valid", int'(ops_valid), 1);
      chk("gap_A", int'(A), 1);
      chk("gap_B", int'(B), 2);
      chk("gap_C", int'(C), 3);
      step();
      exp_cnt++;
      chk("gap_cnt", int'(load_count), int'(exp_cnt));
    end

    // Reset in the middle of a triple.
    send_beat(5'd17);
    chk("mid_busy", int'(busy), 1);
    do_reset();

    // Counter wrap over 256 handshakes.
    ops_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_triple(N'($urandom), N'($urandom), N'($urandom));
      step();
      exp_cnt++;
      if (i == 254) chk("wrap_255", int'(load_count), 255);
      if (i == 255) chk("wrap_0", int'(load_count), 0);
    end
    chk("wrap_model", int'(load_count), int'(exp_cnt));

    // Mid-triple idle: abort only when the timeout feature is built in.
    send_beat(5'd5);
    pulses   = 0;
    pulse_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (timeout_err) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
        chk("to_A", int'(A), 0);
        chk("to_busy", int'(busy), 0);
        chk("to_inrdy", int'(in_ready), 1);
      end
    end
`ifdef LOADER_TIMEOUT_EN
    chk("to_pulses", pulses, 1);
    chk("to_when", pulse_at, 15);
    chk("to_A_end", int'(A), 0);
`else
    chk("to_pulses", pulses, 0);
    chk("to_busy_hold", int'(busy), 1);
    chk("to_A_hold", int'(A), 5);
`endif

    step();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
